// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: gates ball motion, serve delay, scores, winner.
// Latency: miss sampled at edge k -> score pulse / new score after edge k+1.
// Backpressure: none; event pulses are consumed or ignored the cycle they arrive.
//
// Ports:
//   clk, reset (async active-low)
//   start (debounced level, rising edge used), frame_tick, miss_left, miss_right
//   ball_run, serve_dir, score_pulse_l/r, score_l/r, game_over, winner, state
//
// Optional build macro: PONG_PAUSE_EN adds a PAUSE state (encoding 5) entered
// and left with the start button from SERVE or PLAY.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       serve_dir,
  output logic       score_pulse_l,
  output logic       score_pulse_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
`ifdef PONG_PAUSE_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);

  state_t     state_r, state_nxt;
  logic       start_q;
  logic [7:0] cnt_r, cnt_nxt;
  logic       scorer_r, scorer_nxt;   // 1 = right player scored the pending point
  logic       ball_run_nxt, serve_dir_nxt;
  logic       pulse_l_nxt, pulse_r_nxt;
  logic [3:0] score_l_nxt, score_r_nxt;
  logic       game_over_nxt, winner_nxt;
  logic [3:0] inc_l, inc_r;
  logic       start_rise;
`ifdef PONG_PAUSE_EN
  logic       from_serve_r, from_serve_nxt;
`endif

  assign start_rise = start & ~start_q;
  assign inc_l      = score_l + 4'd1;
  assign inc_r      = score_r + 4'd1;

  always_comb begin
    state_nxt     = state_r;
    cnt_nxt       = cnt_r;
    scorer_nxt    = scorer_r;
    serve_dir_nxt = serve_dir;
    pulse_l_nxt   = 1'b0;
    pulse_r_nxt   = 1'b0;
    score_l_nxt   = score_l;
    score_r_nxt   = score_r;
    game_over_nxt = game_over;
    winner_nxt    = winner;
`ifdef PONG_PAUSE_EN
    from_serve_nxt = from_serve_r;
`endif

    case (state_r)
      S_IDLE: begin
        if (start_rise) begin
          score_l_nxt   = 4'd0;
          score_r_nxt   = 4'd0;
          serve_dir_nxt = 1'b0;
          cnt_nxt       = 8'd0;
          state_nxt     = S_SERVE;
        end
      end

      S_SERVE: begin
`ifdef PONG_PAUSE_EN
        if (start_rise) begin
          // Counter is left untouched so the serve wait resumes where it stopped.
          from_serve_nxt = 1'b1;
          state_nxt      = S_PAUSE;
        end else
`endif
        if (frame_tick) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt   = 8'd0;
            state_nxt = S_PLAY;
          end else begin
            cnt_nxt = cnt_r + 8'd1;
          end
        end
      end

      S_PLAY: begin
`ifdef PONG_PAUSE_EN
        if (start_rise) begin
          from_serve_nxt = 1'b0;
          state_nxt      = S_PAUSE;
        end else
`endif
        // miss_left wins a simultaneous double miss; miss_right is dropped.
        if (miss_left) begin
          scorer_nxt = 1'b1;
          state_nxt  = S_POINT;
        end else if (miss_right) begin
          scorer_nxt = 1'b0;
          state_nxt  = S_POINT;
        end
      end

      S_POINT: begin
        // Next serve goes toward the player who conceded.
        if (scorer_r) begin
          pulse_r_nxt   = 1'b1;
          score_r_nxt   = inc_r;
          serve_dir_nxt = 1'b0;
          if (inc_r == WIN_VAL) begin
            game_over_nxt = 1'b1;
            winner_nxt    = 1'b1;
            state_nxt     = S_OVER;
          end else begin
            state_nxt = S_SERVE;
          end
        end else begin
          pulse_l_nxt   = 1'b1;
          score_l_nxt   = inc_l;
          serve_dir_nxt = 1'b1;
          if (inc_l == WIN_VAL) begin
            game_over_nxt = 1'b1;
            winner_nxt    = 1'b0;
            state_nxt     = S_OVER;
          end else begin
            state_nxt = S_SERVE;
          end
        end
      end

      S_OVER: begin
        if (start_rise) begin
          score_l_nxt   = 4'd0;
          score_r_nxt   = 4'd0;
          game_over_nxt = 1'b0;
          winner_nxt    = 1'b0;
          serve_dir_nxt = 1'b0;
          cnt_nxt       = 8'd0;
          state_nxt     = S_SERVE;
        end
      end

`ifdef PONG_PAUSE_EN
      S_PAUSE: begin
        if (start_rise) begin
          state_nxt = from_serve_r ? S_SERVE : S_PLAY;
        end
      end
`endif

      default: state_nxt = S_IDLE;
    endcase

    // Registered from the next state so ball_run tracks PLAY on the same edge.
    ball_run_nxt = (state_nxt == S_PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      start_q       <= 1'b0;
      cnt_r         <= 8'd0;
      scorer_r      <= 1'b0;
      ball_run      <= 1'b0;
      serve_dir     <= 1'b0;
      score_pulse_l <= 1'b0;
      score_pulse_r <= 1'b0;
      score_l       <= 4'd0;
      score_r       <= 4'd0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      start_q       <= start;
      cnt_r         <= cnt_nxt;
      scorer_r      <= scorer_nxt;
      ball_run      <= ball_run_nxt;
      serve_dir     <= serve_dir_nxt;
      score_pulse_l <= pulse_l_nxt;
      score_pulse_r <= pulse_r_nxt;
      score_l       <= score_l_nxt;
      score_r       <= score_r_nxt;
      game_over     <= game_over_nxt;
      winner        <= winner_nxt;
    end
  end

`ifdef PONG_PAUSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      from_serve_r <= 1'b0;
    end else begin
      from_serve_r <= from_serve_nxt;
    end
  end
`endif

  assign state = state_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  logic       clk;
  logic       reset;
  logic       start, frame_tick, miss_left, miss_right;
  logic       ball_run, serve_dir, score_pulse_l, score_pulse_r;
  logic [3:0] score_l, score_r;
  logic       game_over, winner;
  logic [2:0] state;

  int nvec = 0;
  int nmis = 0;

  pong_match_ctrl #(.WIN_SCORE(9), .SERVE_FRAMES(60)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right), .ball_run(ball_run),
    .serve_dir(serve_dir), .score_pulse_l(score_pulse_l),
    .score_pulse_r(score_pulse_r), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner(winner), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation: {ball_run, serve_dir, pulse_l, pulse_r, score_l, score_r, game_over, winner, state}
  function automatic logic [16:0] E(input logic br, input logic sd, input logic pl, input logic pr,
                                    input logic [3:0] sl, input logic [3:0] sr,
                                    input logic go, input logic w, input logic [2:0] st);
    return {br, sd, pl, pr, sl, sr, go, w, st};
  endfunction

  task automatic chk(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {ball_run, serve_dir, score_pulse_l, score_pulse_r, score_l, score_r, game_over, winner, state};
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got br=%b sd=%b pl=%b pr=%b sl=%0d sr=%0d go=%b w=%b st=%0d, expected br=%b sd=%b pl=%b pr=%b sl=%0d sr=%0d go=%b w=%b st=%0d",
               name, act[16], act[15], act[14], act[13], act[12:9], act[8:5], act[4], act[3], act[2:0],
               exp[16], exp[15], exp[14], exp[13], exp[12:9], exp[8:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic st, input logic ft, input logic ml, input logic mr);
    start = st; frame_tick = ft; miss_left = ml; miss_right = mr;
    @(posedge clk);
    #1;
  endtask

  // SERVE -> PLAY: 59 ticks must not release the ball, the 60th must.
  task automatic serve_to_play(input logic sd, input logic [3:0] sl, input logic [3:0] sr, input string name);
    repeat (59) step(0, 1, 0, 0);
    chk({name, "_59"}, E(0, sd, 0, 0, sl, sr, 0, 0, 3'd1));
    step(0, 1, 0, 0);
    chk({name, "_60"}, E(1, sd, 0, 0, sl, sr, 0, 0, 3'd2));
  endtask

  // Left player scores from PLAY; p is the score after the point.
  task automatic point_left(input logic sd_before, input logic [3:0] p, input logic [3:0] sr);
    step(0, 0, 0, 1);
    chk("pt_l_enter", E(0, sd_before, 0, 0, p - 4'd1, sr, 0, 0, 3'd3));
    step(0, 0, 0, 0);
    chk("pt_l_pulse", E(0, 1, 1, 0, p, sr, 0, 0, 3'd1));
  endtask

  typedef struct {
    string       name;
    int          rep;
    logic        st, ft, ml, mr;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input int rep, input logic st, input logic ft,
                     input logic ml, input logic mr, input logic [16:0] exp);
    vec_t v;
    v.name = n; v.rep = rep; v.st = st; v.ft = ft; v.ml = ml; v.mr = mr; v.exp = exp;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    start = 0; frame_tick = 0; miss_left = 0; miss_right = 0;

    add("idle_ticks_ignored", 3,  0, 1, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    add("start_to_serve",     1,  1, 0, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    add("serve_59_ticks",     59, 0, 1, 0, 0, E(0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    add("serve_60th_tick",    1,  0, 1, 0, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 3'd2));
    add("miss_right_point",   1,  0, 0, 0, 1, E(0, 0, 0, 0, 0, 0, 0, 0, 3'd3));
    add("pulse_l",            1,  0, 0, 0, 0, E(0, 1, 1, 0, 1, 0, 0, 0, 3'd1));
    add("pulse_l_one_cycle",  1,  0, 0, 1, 0, E(0, 1, 0, 0, 1, 0, 0, 0, 3'd1));
    add("serve2",             60, 0, 1, 0, 0, E(1, 1, 0, 0, 1, 0, 0, 0, 3'd2));
    add("double_miss",        1,  0, 0, 1, 1, E(0, 1, 0, 0, 1, 0, 0, 0, 3'd3));
    add("pulse_r_only",       1,  0, 0, 0, 0, E(0, 0, 0, 1, 1, 1, 0, 0, 3'd1));
    add("serve3",             60, 0, 1, 0, 0, E(1, 0, 0, 0, 1, 1, 0, 0, 3'd2));

    #3;
    chk("reset_state", E(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      repeat (vq[i].rep) step(vq[i].st, vq[i].ft, vq[i].ml, vq[i].mr);
      chk(vq[i].name, vq[i].exp);
    end

    // Left player runs from 1 up to the winning score.
    point_left(1'b0, 4'd2, 4'd1);
    serve_to_play(1'b1, 4'd2, 4'd1, "lrun");
    for (int p = 3; p <= 8; p++) begin
      point_left(1'b1, 4'(p), 4'd1);
      serve_to_play(1'b1, 4'(p), 4'd1, "lrun");
    end
    step(0, 0, 0, 1);
    chk("win_point_enter", E(0, 1, 0, 0, 8, 1, 0, 0, 3'd3));
    step(0, 0, 0, 0);
    chk("win_pulse", E(0, 1, 1, 0, 9, 1, 1, 0, 3'd4));
    step(0, 0, 0, 0);
    chk("over_hold", E(0, 1, 0, 0, 9, 1, 1, 0, 3'd4));
    step(0, 0, 1, 0);
    step(0, 1, 0, 1);
    chk("over_miss_ignored", E(0, 1, 0, 0, 9, 1, 1, 0, 3'd4));
    step(1, 0, 0, 0);
    chk("restart", E(0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    step(0, 0, 0, 0);

    // Build to score_l = 3 for the mid-match reset.
    serve_to_play(1'b0, 4'd0, 4'd0, "r1");
    point_left(1'b0, 4'd1, 4'd0);
    serve_to_play(1'b1, 4'd1, 4'd0, "r2");
    point_left(1'b1, 4'd2, 4'd0);
    serve_to_play(1'b1, 4'd2, 4'd0, "r3");
    point_left(1'b1, 4'd3, 4'd0);

`ifdef PONG_PAUSE_EN
    repeat (20) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("pause_in_serve", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd5));
    step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("resume_serve", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd1));
    step(0, 0, 0, 0);
    repeat (39) step(0, 1, 0, 0);
    chk("resume_39", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd1));
    step(0, 1, 0, 0);
    chk("resume_40", E(1, 1, 0, 0, 3, 0, 0, 0, 3'd2));
    step(1, 0, 0, 0);
    chk("pause_in_play", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd5));
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("pause_miss_ignored", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd5));
    step(1, 0, 0, 0);
    chk("resume_play", E(1, 1, 0, 0, 3, 0, 0, 0, 3'd2));
    step(0, 0, 0, 0);
`else
    step(1, 0, 0, 0);
    chk("start_in_serve_ignored", E(0, 1, 0, 0, 3, 0, 0, 0, 3'd1));
    step(0, 0, 0, 0);
    serve_to_play(1'b1, 4'd3, 4'd0, "r4");
    step(1, 0, 0, 0);
    chk("start_in_play_ignored", E(1, 1, 0, 0, 3, 0, 0, 0, 3'd2));
    step(0, 0, 0, 0);
`endif

    // Asynchronous reset mid-PLAY: outputs clear before the next edge.
    reset = 1'b0;
    #2;
    chk("async_reset", E(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    step(0, 1, 0, 1);
    chk("reset_held", E(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
    @(negedge clk);
    reset = 1'b1;
    step(0, 1, 1, 0);
    chk("post_reset_idle", E(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
